// File: rtl/chain_best_pred_pkg.sv
// Shared defaults and FSM encodings for the chaining best-predecessor stage.
package chain_best_pred_pkg;

  localparam int DEF_SCORE_W  = 32;
  localparam int DEF_IDX_W    = 16;
  localparam int DEF_MAX_PRED = 64;
  localparam int CNT_W        = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

endpackage

// File: rtl/chain_sat_add.sv
// Registered signed saturating adder: sum_o = clamp(a_i + b_i) one cycle later.
module chain_sat_add #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0]   wide;
  logic signed [W-1:0] sum_d, sum_q;

  always_comb begin
    wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // Overflow shows as disagreement between the extra sign bit and the result MSB.
    if (wide[W] != wide[W-1]) sum_d = wide[W] ? MINV : MAXV;
    else                      sum_d = wide[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/chain_best_pred.sv
// DP max-reduction: f[i] = max(W_i, max_j(f[j]+score(i,j))) with arg-max predecessor.
//  state  | meaning
//  IDLE   | waiting for the first beat of an anchor
//  ACCUM  | accepting candidate beats of the current anchor
//  FLUSH  | last beat sits in S1; final compare happens this cycle
//  EMIT   | result presented, waiting for out_ready
module chain_best_pred
  import chain_best_pred_pkg::*;
#(
  parameter int SCORE_W  = DEF_SCORE_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MAX_PRED = DEF_MAX_PRED
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      in_skip,
  input  logic signed [SCORE_W-1:0] in_w,
  input  logic signed [SCORE_W-1:0] in_score,
  input  logic signed [SCORE_W-1:0] in_fj,
  input  logic [IDX_W-1:0]          in_j,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [SCORE_W-1:0] out_f,
  output logic [IDX_W-1:0]          out_pred,
  output logic                      out_has_pred,
  output logic [CNT_W-1:0]          out_count,
  output logic                      err_proto
);

  logic [1:0] state_q, state_d;
  logic       accept, keep, err_d, err_q;

  logic                      s1_valid_q, s1_first_q, s1_skip_q;
  logic signed [SCORE_W-1:0] s1_w_q, s1_sum;
  logic [IDX_W-1:0]          s1_j_q;

  logic signed [SCORE_W-1:0] best_q, best_d, base_best;
  logic [IDX_W-1:0]          pred_q, pred_d, base_pred;
  logic                      has_q, has_d, base_has;
  logic [CNT_W-1:0]          count_q, count_d, base_count;
  logic                      cand, cap_ok, upd;

  logic signed [SCORE_W-1:0] out_f_q;
  logic [IDX_W-1:0]          out_pred_q;
  logic                      out_has_q;
  logic [CNT_W-1:0]          out_count_q;

  assign in_ready = !reset && (state_q == ST_IDLE || state_q == ST_ACCUM);
  assign accept   = in_valid && in_ready;
  // Beats without in_first are only meaningful inside an anchor.
  assign keep     = accept && (in_first || state_q == ST_ACCUM);
  assign err_d    = accept && ((state_q == ST_IDLE && !in_first) ||
                               (state_q == ST_ACCUM && in_first));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && in_first) state_d = in_last ? ST_FLUSH : ST_ACCUM;
      ST_ACCUM: if (accept && in_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_EMIT;
      ST_EMIT:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  chain_sat_add #(.W(SCORE_W)) u_sat_add (
    .clk   (clk),
    .reset (reset),
    .a_i   (in_fj),
    .b_i   (in_score),
    .sum_o (s1_sum)
  );

  // S2: a first beat reseeds the running state before being evaluated itself.
  always_comb begin
    base_best  = s1_first_q ? s1_w_q : best_q;
    base_pred  = s1_first_q ? '1 : pred_q;
    base_has   = s1_first_q ? 1'b0 : has_q;
    base_count = s1_first_q ? '0 : count_q;
    cand       = s1_valid_q && !s1_skip_q;
    cap_ok     = base_count < CNT_W'(MAX_PRED);
    upd        = cand && cap_ok && (s1_sum > base_best);
    best_d     = upd ? s1_sum : base_best;
    pred_d     = upd ? s1_j_q : base_pred;
    has_d      = upd ? 1'b1 : base_has;
    count_d    = (cand && cap_ok) ? base_count + 1'b1 : base_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_skip_q   <= 1'b0;
      s1_w_q      <= '0;
      s1_j_q      <= '0;
      best_q      <= '0;
      pred_q      <= '1;
      has_q       <= 1'b0;
      count_q     <= '0;
      out_f_q     <= '0;
      out_pred_q  <= '1;
      out_has_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      s1_valid_q <= keep;
      if (keep) begin
        s1_first_q <= in_first;
        s1_skip_q  <= in_skip;
        s1_w_q     <= in_w;
        s1_j_q     <= in_j;
      end
      if (s1_valid_q) begin
        best_q  <= best_d;
        pred_q  <= pred_d;
        has_q   <= has_d;
        count_q <= count_d;
      end
      if (state_q == ST_FLUSH) begin
        out_f_q     <= best_d;
        out_pred_q  <= pred_d;
        out_has_q   <= has_d;
        out_count_q <= count_d;
      end
    end
  end

  assign out_valid    = (state_q == ST_EMIT);
  assign out_f        = out_f_q;
  assign out_pred     = out_pred_q;
  assign out_has_pred = out_has_q;
  assign out_count    = out_count_q;
  assign err_proto    = err_q;

endmodule
